// File: rtl/spi_slave_rx_tx.sv
// spi_slave_rx_tx: SPI responder, all four modes, MSB-first 8-bit words, single-entry tx buffer
`timescale 1ns/1ps
module spi_slave_rx_tx #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  IDLE_BYTE   = 8'h00
) (
    input  logic       iclk,
    input  logic       rst,
    input  logic [1:0] mode,
    input  logic       SCK,
    input  logic       CSN,
    input  logic       MOSI,
    output logic       MISO,
    output logic       miso_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_underrun,
    output logic       busy
);
    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state, state_nxt;
    logic [SYNC_STAGES-1:0] sck_q, csn_q, mosi_q;
    logic sck_d, csn_d;
    logic cpol, cpha, first, boundary, buf_full;
    logic [2:0] cnt;
    logic [6:0] rx_shift;
    logic [7:0] tx_shift, buf_data, load_byte;
    logic sck_s, csn_s, mosi_s, sck_rise, sck_fall, csn_fall, csn_rise;
    logic start, stop, run, lead, trail, sample, shift, reload, wr;

    assign sck_s     = sck_q[SYNC_STAGES-1];
    assign csn_s     = csn_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_q[SYNC_STAGES-1];
    assign sck_rise  = sck_s & ~sck_d;
    assign sck_fall  = ~sck_s & sck_d;
    assign csn_fall  = ~csn_s & csn_d;
    assign csn_rise  = csn_s & ~csn_d;
    assign start     = (state == IDLE) && csn_fall;
    assign stop      = (state == ACTIVE) && csn_rise;
    assign run       = (state == ACTIVE) && !csn_rise;
    assign lead      = cpol ? sck_fall : sck_rise;
    assign trail     = cpol ? sck_rise : sck_fall;
    assign sample    = run && (cpha ? trail : lead);
    assign shift     = run && (cpha ? lead : trail);
    // a reload sees the buffer as it was before any same-cycle write
    assign reload    = start || (shift && boundary);
    assign load_byte = buf_full ? buf_data : IDLE_BYTE;
    assign wr        = tx_valid && !buf_full;

    // synchronise the pins and keep one extra copy of each for edge detection
    always_ff @(posedge iclk or posedge rst) begin
        if (rst) begin
            sck_q  <= '0;
            csn_q  <= '1;
            mosi_q <= '0;
            sck_d  <= 1'b0;
            csn_d  <= 1'b1;
        end else begin
            sck_q  <= {sck_q[SYNC_STAGES-2:0], SCK};
            csn_q  <= {csn_q[SYNC_STAGES-2:0], CSN};
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], MOSI};
            sck_d  <= sck_s;
            csn_d  <= csn_s;
        end
    end

    // frame state register
    always_ff @(posedge iclk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // frame opens on CSN falling, closes on CSN rising
    always_comb begin
        state_nxt = (state == IDLE) ? (csn_fall ? ACTIVE : IDLE) : (csn_rise ? IDLE : ACTIVE);
    end

    // status outputs decoded from the frame state and buffer flag
    always_comb begin
        busy     = (state == ACTIVE);
        miso_oe  = (state == ACTIVE);
        tx_ready = !buf_full;
    end

    // shift datapath, tx buffer and single-cycle status pulses
    always_ff @(posedge iclk or posedge rst) begin
        if (rst) begin
            cpol        <= 1'b0;
            cpha        <= 1'b0;
            first       <= 1'b0;
            boundary    <= 1'b0;
            cnt         <= 3'd0;
            rx_shift    <= 7'd0;
            tx_shift    <= 8'd0;
            rx_data     <= 8'd0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            MISO        <= 1'b0;
            buf_full    <= 1'b0;
            buf_data    <= 8'd0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= reload && !buf_full;
            buf_full    <= wr || (buf_full && !reload);
            if (wr) buf_data <= tx_data;
            if (start) begin
                cpol     <= mode[1];
                cpha     <= mode[0];
                first    <= mode[0];
                boundary <= 1'b0;
                cnt      <= 3'd0;
                tx_shift <= load_byte;
                MISO     <= load_byte[7];
            end else if (stop) begin
                first    <= 1'b0;
                boundary <= 1'b0;
                cnt      <= 3'd0;
                MISO     <= 1'b0;
            end else begin
                if (sample) begin
                    rx_shift <= {rx_shift[5:0], mosi_s};
                    cnt      <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        rx_data  <= {rx_shift, mosi_s};
                        rx_valid <= 1'b1;
                        boundary <= 1'b1;
                    end
                end
                if (shift) begin
                    if (boundary) begin
                        tx_shift <= load_byte;
                        MISO     <= load_byte[7];
                        boundary <= 1'b0;
                    end else if (first) begin
                        first <= 1'b0;
                        MISO  <= tx_shift[7];
                    end else begin
                        tx_shift <= {tx_shift[6:0], 1'b0};
                        MISO     <= tx_shift[6];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_rx_tx.sv
// tb_spi_slave_rx_tx: drives the responder as an SPI master and checks against a byte-level model
`timescale 1ns/1ps
module tb_spi_slave_rx_tx;
    localparam int H = 63;
    logic       iclk = 1'b0, rst = 1'b1;
    logic [1:0] mode = 2'd0;
    logic       SCK = 1'b0, CSN = 1'b1, MOSI = 1'b0;
    logic       MISO, miso_oe, tx_ready, rx_valid, tx_underrun, busy;
    logic [7:0] tx_data = 8'd0, rx_data;
    logic       tx_valid = 1'b0;

    int n_chk = 0, n_pass = 0;
    int ur_cnt = 0, ur_exp = 0;
    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    logic [7:0] ld_q[$];
    logic [7:0] last_rx = 8'd0;

    spi_slave_rx_tx dut (
        .iclk(iclk), .rst(rst), .mode(mode), .SCK(SCK), .CSN(CSN), .MOSI(MOSI),
        .MISO(MISO), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_underrun(tx_underrun), .busy(busy)
    );

    always #5 iclk = ~iclk;

    // record every completed byte and every underrun pulse
    always @(negedge iclk) begin
        if (!rst) begin
            if (rx_valid) rxq.push_back(rx_data);
            if (tx_underrun) ur_cnt++;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // one buffer load as the master sees it: the queued byte, or the idle byte
    task automatic reload_model();
        if (txq.size() > 0) ld_q.push_back(txq.pop_front());
        else begin
            ld_q.push_back(8'h00);
            ur_exp++;
        end
    endtask

    task automatic tx_write(input logic [7:0] d);
        int t;
        t = 0;
        @(negedge iclk);
        while (!tx_ready && t < 50) begin
            @(negedge iclk);
            t++;
        end
        if (!tx_ready) check("tx_ready_wait", 0, 1);
        tx_valid = 1'b1;
        tx_data  = d;
        @(negedge iclk);
        tx_valid = 1'b0;
        txq.push_back(d);
    endtask

    task automatic frame(input logic [1:0] m, input int nbits, input logic [31:0] mo,
                         input bit wr2_en, input logic [7:0] wr2);
        int base_rx, base_ur, nrel, nfull;
        logic [31:0] mi, exp_mi;
        logic [7:0] b;
        base_rx = rxq.size();
        base_ur = ur_cnt;
        ur_exp  = 0;
        ld_q.delete();
        mode = m;
        SCK  = m[1];
        MOSI = mo[nbits-1];
        #(4*H);
        CSN = 1'b0;
        reload_model();
        #H;
        if (wr2_en) tx_write(wr2);
        mi = 0;
        for (int i = 0; i < nbits; i++) begin
            if (!m[0]) begin
                MOSI = mo[nbits-1-i];
                SCK  = ~m[1];
                mi   = {mi[30:0], MISO};
                #H;
                SCK  = m[1];
                #H;
            end else begin
                SCK  = ~m[1];
                MOSI = mo[nbits-1-i];
                #H;
                SCK  = m[1];
                mi   = {mi[30:0], MISO};
                #H;
            end
        end
        CSN = 1'b1;
        #(4*H);
        nfull = nbits / 8;
        nrel  = m[0] ? (nbits - 1) / 8 : nfull;
        repeat (nrel) reload_model();
        exp_mi = 0;
        for (int i = 0; i < nbits; i++) begin
            b = ld_q[i/8];
            exp_mi = {exp_mi[30:0], b[7-(i%8)]};
        end
        check($sformatf("miso m%0d", m), mi, exp_mi);
        check($sformatf("rx_count m%0d", m), rxq.size() - base_rx, nfull);
        for (int k = 0; k < nfull; k++) begin
            b = 8'((mo >> (nbits - 8*(k+1))) & 32'hff);
            if (rxq.size() > base_rx + k) check($sformatf("rx_byte%0d m%0d", k, m), rxq[base_rx+k], b);
            last_rx = b;
        end
        check("rx_data_hold", rx_data, last_rx);
        check("underruns", ur_cnt - base_ur, ur_exp);
        check("idle_outputs", {busy, miso_oe, MISO}, 3'b000);
        check("tx_ready", tx_ready, txq.size() == 0);
    endtask

    initial begin
        logic [1:0] m;
        int nb;
        logic [31:0] mo;
        repeat (4) @(negedge iclk);
        check("rst_miso", MISO, 0);
        check("rst_oe", miso_oe, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_flags", {rx_valid, tx_underrun, busy}, 0);
        check("rst_tx_ready", tx_ready, 1);
        rst = 1'b0;
        repeat (4) @(negedge iclk);

        tx_write(8'h3C);
        frame(2'd0, 8, 32'hA5, 0, 8'h00);
        for (int i = 1; i < 4; i++) begin
            tx_write(8'hC3);
            frame(2'(i), 8, 32'h5A, 0, 8'h00);
        end
        tx_write(8'h11);
        frame(2'd0, 16, 32'hF00F, 1, 8'h22);
        frame(2'd1, 8, 32'h96, 0, 8'h00);
        frame(2'd0, 5, 32'h16, 0, 8'h00);
        frame(2'd0, 8, 32'h81, 0, 8'h00);

        // reset in the middle of a mode 3 byte
        tx_write(8'h4B);
        mode = 2'd3;
        SCK  = 1'b1;
        #(4*H);
        CSN = 1'b0;
        #H;
        repeat (3) begin
            SCK = 1'b0; MOSI = 1'b1; #H;
            SCK = 1'b1; #H;
        end
        SCK = 1'b0;
        #(H/2);
        rst = 1'b1;
        #1;
        check("midrst_miso_oe", {MISO, miso_oe}, 0);
        check("midrst_rx_data", rx_data, 0);
        check("midrst_flags", {rx_valid, tx_underrun, busy}, 0);
        check("midrst_tx_ready", tx_ready, 1);
        CSN = 1'b1;
        SCK = 1'b1;
        txq.delete();
        last_rx = 8'd0;
        repeat (4) @(negedge iclk);
        rst = 1'b0;
        repeat (4) @(negedge iclk);
        tx_write(8'hA9);
        frame(2'd3, 8, 32'h7E, 0, 8'h00);

        repeat (8) begin
            m  = 2'($urandom_range(0, 3));
            nb = $urandom_range(0, 1) ? 16 : 8;
            mo = $urandom;
            if (txq.size() == 0 && $urandom_range(0, 1) == 1) tx_write(8'($urandom));
            frame(m, nb, mo, (nb == 16) && ($urandom_range(0, 1) == 1), 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/spi_slave_rx_tx.md
Name: spi_slave_rx_tx

Overview:
- SPI responder (slave) for the far end of the team's SPI master link.
- Oversamples the external SCK/CSN/MOSI on the system clock iclk and supports all four SPI modes.
- Shifts 8-bit words MSB-first in both directions: returns received bytes on rx_data/rx_valid and drives MISO from a single-entry transmit buffer filled through a valid/ready handshake.
- Supports multi-byte bursts within one CSN-low window.

Parameters:
- SYNC_STAGES, 2: flip-flop depth of the input synchronisers on SCK, CSN and MOSI. Minimum 2.
- IDLE_BYTE, 8'h00: byte shifted out when the transmit buffer is empty at a byte boundary.

Ports:
- iclk  input  1  system clock. Every register is clocked on its rising edge.
- rst  input  1  reset: asynchronous, active-high.
- mode  input  2  SPI mode. CPOL=mode[1], CPHA=mode[0]. Captured at frame start.
- SCK  input  1  serial clock from the master (asynchronous to iclk).
- CSN  input  1  chip select from the master, active-low.
- MOSI  input  1  serial data from the master.
- MISO  output  1  serial data to the master.
- miso_oe  output  1  high while a frame is active. Used by the top level as the pad enable.
- tx_data  input  8  byte to transmit.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  transmit buffer is empty.
- rx_data  output  8  last complete received byte.
- rx_valid  output  1  single-cycle pulse when rx_data is updated.
- tx_underrun  output  1  single-cycle pulse when IDLE_BYTE is loaded because the buffer was empty.
- busy  output  1  high while in the ACTIVE state.

Behaviour:
- Reset values:
  - MISO=0, miso_oe=0, rx_data=8'h00, rx_valid=0, tx_underrun=0, busy=0, tx_ready=1.
  - Internal state: IDLE, bit counter=0, shift registers=0, tx buffer empty.
  - Synchronisers preset to SCK=CPOL of mode 0 (i.e. 0), CSN=1, MOSI=0.
- Synchronisation and edge detection:
  - SCK, CSN and MOSI each pass through SYNC_STAGES flops.
  - Edges are detected by comparing the last synchronised stage with one extra registered copy.
  - Timing requirement on the master: SCK high and low times are each at least SYNC_STAGES+1 iclk periods.
- Edge naming:
  - Leading edge: SCK transition away from CPOL (rising when CPOL=0).
  - Trailing edge: the opposite transition.
  - CPHA=0: sample MOSI on the leading edge, shift on the trailing edge.
  - CPHA=1: shift on the leading edge, sample on the trailing edge.
- State machine has two states, IDLE and ACTIVE.
- IDLE -> ACTIVE on a synchronised CSN falling edge. In that same cycle:
  - Latch mode.
  - Clear the bit counter.
  - Load the tx shift register from the buffer if it is full (buffer becomes empty, tx_ready rises next cycle). Otherwise load IDLE_BYTE and pulse tx_underrun.
  - CPHA=0: MISO presents bit 7 in the same cycle.
  - CPHA=1: MISO presents bit 7 at the first leading edge; before that it holds the loaded bit 7.
- In ACTIVE, on each sample edge:
  - rx shift register <= {rx_shift[6:0], MOSI_sync}.
  - Bit counter increments.
  - When the count reaches 8:
    - rx_data <= completed byte.
    - rx_valid pulses high for one cycle, in the same cycle as the 8th sample.
    - Counter wraps to 0.
    - Flag a byte boundary.
- In ACTIVE, on each shift edge:
  - If a byte boundary is pending, reload the tx shift register from the buffer (or IDLE_BYTE with tx_underrun) and clear the flag.
  - Otherwise shift left.
  - MISO = shift register bit 7.
  - CPHA=1: the first shift edge of a frame presents bit 7 without shifting.
- ACTIVE -> IDLE on a synchronised CSN rising edge:
  - A partial byte is discarded: no rx_valid, counter cleared.
  - MISO=0 and miso_oe=0 from the next cycle.
- Latency: MISO and rx_valid respond SYNC_STAGES+1 iclk cycles after the corresponding SCK pin edge.
- Transmit buffer handshake:
  - A write occurs when tx_valid && tx_ready.
  - tx_ready drops the following cycle.
  - A write and a reload in the same cycle: the reload takes the old (empty) buffer state, so IDLE_BYTE is sent and the write is kept for the next byte.
- rx_data holds its value until the next completed byte. There is no consumer back-pressure; a byte that is not read before the next one completes is overwritten.
- SCK edges while CSN is high are ignored.
- mode changes while busy are ignored until the next frame.
- rst mid-frame returns everything to reset values immediately. The frame then resumes only on a new CSN falling edge.

Test Plan:
- Mode 0, tx buffer=8'h3C, master sends 8'hA5 -> master receives 8'h3C; rx_data=8'hA5; exactly one rx_valid pulse; tx_ready returns to 1 after frame start.
- Modes 1, 2 and 3, each with tx=8'hC3, master sends 8'h5A -> 8'hC3 returned and rx_data=8'h5A in every mode; MISO=0 and miso_oe=0 outside CSN-low.
- Two-byte burst in mode 0: tx writes 8'h11 then 8'h22 (second write after tx_ready), master sends 8'hF0, 8'h0F -> MISO carries 8'h11 then 8'h22; rx_valid pulses twice with F0 then 0F.
- Empty buffer at frame start -> MISO shifts 8'h00; tx_underrun pulses once; rx still completes normally.
- CSN raised after 5 SCK cycles -> no rx_valid; rx_data unchanged; busy=0. The next full frame with 8'h81 gives rx_data=8'h81.
- rst asserted mid-byte in mode 3 -> all outputs return to reset values in the same cycle. A new frame sending 8'h7E is received correctly.
